// File: rtl/br_tag_alloc_pkg.sv
// Shared constants for the branch-tag allocator and the blocks that consume branch masks.
package br_tag_alloc_pkg;
  localparam int NBR_DFLT = 6;
  localparam logic [NBR_DFLT-1:0] BRM_ZERO = '0;
  localparam logic [NBR_DFLT-1:0] BRM_ONE  = NBR_DFLT'(1);
endpackage

// File: rtl/br_prio_enc.sv
// Lowest-zero priority encoder: one-hot of the lowest clear bit plus an any-free flag.
module br_prio_enc
  import br_tag_alloc_pkg::*;
#(
  parameter int N = NBR_DFLT
) (
  input  logic [N-1:0] busy,
  output logic [N-1:0] onehot,
  output logic         any_free
);

  logic [N-1:0] free;

  assign free     = ~busy;
  // Two's-complement trick isolates the lowest set bit of the free vector.
  assign onehot   = free & (~free + N'(1));
  assign any_free = |free;

endmodule

// File: rtl/br_tag_alloc.sv
// Branch-tag allocator: hands out one-hot tags, tracks per-tag age via dep, frees/kills on resolve.
// Optional statistics counters are enabled with the BRTAG_STATS_EN macro.
module br_tag_alloc
  import br_tag_alloc_pkg::*;
#(
  parameter int NBR = NBR_DFLT
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_dec_valid,
  input  logic           i_dec_br,
  output logic           o_grant,
  output logic [NBR-1:0] o_tag,
  output logic [NBR-1:0] o_brmask,
  output logic           o_stall,
  input  logic           i_res_valid,
  input  logic [NBR-1:0] i_res_tag,
  input  logic           i_res_mispred,
  output logic [NBR-1:0] o_clr_mask,
  output logic [NBR-1:0] o_kill_mask,
  output logic [NBR-1:0] o_busy
`ifdef BRTAG_STATS_EN
  ,
  output logic [31:0]    o_cnt_alloc,
  output logic [31:0]    o_cnt_mispred,
  output logic [31:0]    o_cnt_stall
`endif
);

  logic [NBR-1:0] busy;
  logic [NBR-1:0] busy_n;
  logic [NBR-1:0] dep   [NBR];
  logic [NBR-1:0] dep_n [NBR];
  logic [NBR-1:0] free_oh;
  logic [NBR-1:0] eff_busy;
  logic [NBR-1:0] kill;
  logic [NBR-1:0] clr_mask;
  logic [NBR-1:0] kill_mask;
  logic           any_free;
  logic           res_hit;
  logic           res_ok;
  logic           res_bad;
  logic           grant;

  br_prio_enc #(.N(NBR)) u_enc (
    .busy     (busy),
    .onehot   (free_oh),
    .any_free (any_free)
  );

  // A resolve naming a tag that is not outstanding has no effect.
  assign res_hit  = i_res_valid & (|(i_res_tag & busy));
  assign res_ok   = res_hit & ~i_res_mispred;
  assign res_bad  = res_hit & i_res_mispred;
  assign eff_busy = busy & ~((i_res_valid & ~i_res_mispred) ? i_res_tag : '0);
  assign grant    = i_dec_valid & i_dec_br & any_free & ~(i_res_valid & i_res_mispred);

  assign o_grant     = grant;
  assign o_tag       = grant ? free_oh : '0;
  assign o_brmask    = eff_busy;
  assign o_stall     = i_dec_valid & i_dec_br & ~any_free;
  assign o_busy      = busy;
  assign o_clr_mask  = clr_mask;
  assign o_kill_mask = kill_mask;

  // Younger tags are exactly those whose captured age vector contains the mispredicted tag.
  always_comb begin
    kill = '0;
    if (res_bad) begin
      kill = i_res_tag;
      for (int j = 0; j < NBR; j++) begin
        if (busy[j] && (|(dep[j] & i_res_tag))) kill[j] = 1'b1;
      end
    end
  end

  always_comb begin
    busy_n = busy;
    if (res_ok) busy_n = busy_n & ~i_res_tag;
    busy_n = busy_n & ~kill;
    if (grant) busy_n = busy_n | free_oh;
    for (int j = 0; j < NBR; j++) begin
      dep_n[j] = dep[j];
      if (res_ok) dep_n[j] = dep_n[j] & ~i_res_tag;
      if (kill[j]) dep_n[j] = '0;
      if (grant && free_oh[j]) dep_n[j] = eff_busy;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      busy      <= '0;
      clr_mask  <= '0;
      kill_mask <= '0;
      for (int j = 0; j < NBR; j++) dep[j] <= '0;
    end else begin
      busy      <= busy_n;
      clr_mask  <= res_ok ? i_res_tag : '0;
      kill_mask <= kill;
      for (int j = 0; j < NBR; j++) dep[j] <= dep_n[j];
    end
  end

`ifdef BRTAG_STATS_EN
  logic [31:0] cnt_alloc;
  logic [31:0] cnt_mispred;
  logic [31:0] cnt_stall;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_alloc   <= '0;
      cnt_mispred <= '0;
      cnt_stall   <= '0;
    end else begin
      cnt_alloc   <= cnt_alloc + 32'(grant);
      cnt_mispred <= cnt_mispred + 32'(res_bad);
      cnt_stall   <= cnt_stall + 32'(o_stall);
    end
  end

  assign o_cnt_alloc   = cnt_alloc;
  assign o_cnt_mispred = cnt_mispred;
  assign o_cnt_stall   = cnt_stall;
`endif

endmodule

// File: doc/br_tag_alloc.md
Name: br_tag_alloc

Overview:
- Branch-tag allocator and scheduler between the decode stage and dispatch.
- Gives every decoded jump/branch (decode `o_en_j`) a one-hot branch tag and tells decode the current outstanding-branch mask to attach to the instruction.
- Frees tags when the execute stage resolves branches, and returns the kill mask of all younger tags on a mispredict.
- Asserts stall when no tag is free.

Parameters:
- NBR, 6, number of branch tags; equals the branch-mask width (WIDTH_BRM) used by decode and dispatch.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_dec_valid  in  1  decode slot holds a valid instruction this cycle.
- i_dec_br  in  1  decoded instruction needs a tag (decode `o_en_j`).
- o_grant  out  1  tag allocated this cycle.
- o_tag  out  NBR  one-hot allocated tag; zero when o_grant=0.
- o_brmask  out  NBR  mask of older unresolved branches to attach to the decoded instruction.
- o_stall  out  1  decode must hold: i_dec_valid & i_dec_br & no free tag.
- i_res_valid  in  1  a branch resolves this cycle.
- i_res_tag  in  NBR  one-hot tag of the resolving branch.
- i_res_mispred  in  1  resolution was a mispredict.
- o_clr_mask  out  NBR  tags freed as correctly predicted; registered, one-cycle pulse, broadcast to the queues to clear brmask bits.
- o_kill_mask  out  NBR  tags squashed; registered, one-cycle pulse, broadcast to the queues to kill entries.
- o_busy  out  NBR  current allocated-tag vector.

Behaviour:
- State: busy[NBR]; dep[NBR][NBR], where dep[t] = the busy vector captured when t was allocated (tags older than t).
- Reset (i_rst_n=0 at the edge): busy, dep, o_clr_mask and o_kill_mask all go to 0. Reset wins over every other input that cycle.
- Allocation is combinational from registered busy.
  - The free tag is the lowest-index 0 bit of busy.
  - o_grant = i_dec_valid & i_dec_br & any_free & ~(i_res_valid & i_res_mispred).
  - o_tag is one-hot of the chosen index.
  - At the edge: busy[t] <= 1 and dep[t] <= eff_busy.
- eff_busy = busy & ~(i_res_valid & ~i_res_mispred ? i_res_tag : 0).
  - o_brmask = eff_busy. A branch resolving correctly in the same cycle is not attached.
- Full: with all tags busy, o_stall=1, o_grant=0, and no state change from decode.
  - A correct resolve in that same cycle frees a tag only at the edge. No same-cycle reuse; stall drops the next cycle.
- Correct resolve (i_res_valid & ~i_res_mispred), tag r:
  - busy[r] <= 0.
  - Bit r is cleared in every dep[j].
  - o_clr_mask <= r next cycle.
- Mispredict, tag r:
  - kill = r | {j : busy[j] & dep[j][r]}.
  - busy <= busy & ~kill.
  - dep[j] <= 0 for every killed j.
  - o_kill_mask <= kill next cycle.
  - Allocation is suppressed that cycle (younger path is being flushed). o_stall follows its normal definition.
- Resolve of a tag not in busy is ignored: no state change, both masks 0. The bench flags this via assertion.
- o_clr_mask and o_kill_mask are 0 in every cycle without a valid resolve. They are never both nonzero.
- i_res_tag is one-hot only; multi-hot input is illegal and covered by an assertion.
- Wrap-around: tags are reused in any order. Age is carried only by dep, never by index.

Optional Feature:
- Macro BRTAG_STATS_EN.
- When defined, adds outputs o_cnt_alloc[31:0], o_cnt_mispred[31:0] and o_cnt_stall[31:0]:
  - free-running counters of grants, mispredict resolves and stall cycles;
  - reset to 0 and wrap at 2^32.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package: NBR default, and the BRM one-hot helper constants (ZERO mask, ONE mask).
- One sub-module `br_prio_enc` (lowest-zero priority encoder, NBR-in to one-hot-out plus any_free). It is reused later by issue-queue select.

Test Plan:
- Reset, then i_dec_valid=1, i_dec_br=1 for 3 cycles -> o_tag 000001, 000010, 000100; o_brmask 000000, 000001, 000011; o_busy ends at 000111.
- Allocate all 6, then request again -> o_stall=1, o_grant=0. Correct resolve of 000100 the same cycle -> stall remains this cycle; next cycle grant with o_tag=000100 and o_brmask=111011.
- Tags 0,1,2 allocated in order; mispredict on 000010 -> next cycle o_kill_mask=000110, o_busy=000001, o_clr_mask=0.
- Tags 0,1 busy; correct resolve of 000001 while decode requests -> o_grant=1, o_tag=000100, o_brmask=000010; next cycle o_clr_mask=000001.
- Mispredict concurrent with a decode request -> o_grant=0, no new busy bit.
- Pulse i_rst_n=0 for one cycle while 4 tags are busy and a resolve is in flight -> next cycle busy, o_clr_mask and o_kill_mask all 0; if BRTAG_STATS_EN is defined, the counters read 0.
